// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: fetch sequencer states and instruction size.
package riscv_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, instr} entries between the fetch sequencer and ID.
// Flush empties it at the next edge; the head reads as zero when empty.
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty     = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  // A pop frees the slot in the same cycle, so a full buffer still accepts.
  assign w_do_push = push && (!w_full || pop);
  assign w_do_pop  = pop && !empty;
  assign count     = r_count;
  assign head      = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, runs one outstanding req/ack to IMEM,
// buffers returned instructions toward ID and handles EX redirects.
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_target,
  input  logic         id_ready,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic         fetch_valid,
  output logic [31:0]  fetch_pc,
  output logic [31:0]  fetch_instr,
  output logic [31:0]  stall_cycles,
  output fetch_state_e dbg_state
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  // Handshake: imem_req rises with a stable imem_addr and both hold until the
  // cycle imem_ack is seen high (which may be the first cycle of the request);
  // toward ID an entry transfers in any cycle with fetch_valid && id_ready.

  fetch_state_e  r_state;
  fetch_state_e  w_state_nx;
  logic [31:0]   r_next_pc;
  logic [31:0]   r_addr;
  logic [31:0]   r_stall;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [63:0]   w_head;
  logic [31:0]   w_redirect_pc;

  assign w_redirect_pc = redirect_target & ~32'h3;

  always_comb begin
    w_state_nx = r_state;
    w_issue    = 1'b0;
    w_push     = 1'b0;
    case (r_state)
      BOOT:  w_state_nx = FETCH;
      FETCH: begin
        // Gate on the registered count only; a same-cycle pop does not help.
        if (!redirect_valid && (w_count < CW'(BUF_DEPTH))) begin
          w_issue    = 1'b1;
          w_state_nx = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          w_push     = !redirect_valid;
          w_state_nx = FETCH;
        end else if (redirect_valid) begin
          w_state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_ack) w_state_nx = FETCH;
      end
      default: w_state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= BOOT;
      r_next_pc <= RESET_PC;
      r_addr    <= '0;
      r_stall   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (redirect_valid)  r_next_pc <= w_redirect_pc;
      else if (w_push)     r_next_pc <= r_addr + INSTR_BYTES;
      if (w_issue)         r_addr <= r_next_pc;
      if (!fetch_valid && (r_state != BOOT) && (r_stall != 32'hFFFF_FFFF))
        r_stall <= r_stall + 32'd1;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .W     (64)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (w_push),
    .push_data ({r_addr, imem_rdata}),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign imem_req     = (r_state == WAIT) || (r_state == DRAIN);
  assign imem_addr    = r_addr;
  assign fetch_valid  = !w_empty && !redirect_valid;
  assign w_pop        = fetch_valid && id_ready;
  assign fetch_pc     = w_head[63:32];
  assign fetch_instr  = w_head[31:0];
  assign stall_cycles = r_stall;
  assign dbg_state    = r_state;

  a_ack_only_when_pending: assert property (
    @(posedge clk) disable iff (reset) imem_ack |-> imem_req
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: memory responder with programmable wait
// states, delivery/ack monitors, and one task per scenario.
module tb_fetch_ctrl;
  import riscv_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_target = '0;
  logic         id_ready = 1'b0;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack = 1'b0;
  logic [31:0]  imem_rdata = '0;
  logic         fetch_valid;
  logic [31:0]  fetch_pc;
  logic [31:0]  fetch_instr;
  logic [31:0]  stall_cycles;
  fetch_state_e dbg_state;

  int n_pass = 0;
  int n_total = 0;
  int mem_wait = 0;
  int wcnt = 0;

  logic [63:0] got_q[$];
  logic [31:0] ack_q[$];
  logic [31:0] exp_q[$];

  fetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_ready        (id_ready),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .fetch_valid     (fetch_valid),
    .fetch_pc        (fetch_pc),
    .fetch_instr     (fetch_instr),
    .stall_cycles    (stall_cycles),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    got_q.delete();
    ack_q.delete();
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // ---------------- memory responder (driver) ----------------
  always begin
    @(posedge clk); #1;
    if (reset || !imem_req) begin
      imem_ack = 1'b0;
      wcnt = 0;
    end else if (wcnt >= mem_wait) begin
      imem_ack = 1'b1;
      imem_rdata = mem_word(imem_addr);
      wcnt = 0;
    end else begin
      imem_ack = 1'b0;
      wcnt++;
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (fetch_valid && id_ready) got_q.push_back({fetch_pc, fetch_instr});
      if (imem_req && imem_ack) ack_q.push_back(imem_addr);
    end
  end

  task automatic wait_deliv(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (got_q.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", imem_addr); else n_pass++;
    n_total++; if (fetch_valid !== 1'b0) $display("FAIL rst_fv: got %b want 0", fetch_valid); else n_pass++;
    n_total++; if (fetch_pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", fetch_pc); else n_pass++;
    n_total++; if (fetch_instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", fetch_instr); else n_pass++;
    n_total++; if (stall_cycles !== 32'h0) $display("FAIL rst_stall: got %0d want 0", stall_cycles); else n_pass++;
    n_total++; if (dbg_state !== BOOT) $display("FAIL rst_state: got %0d want %0d", dbg_state, BOOT); else n_pass++;
  endtask

  task automatic test_zero_wait();
    bit ok;
    mem_wait = 0; id_ready = 1'b1;
    do_reset();
    @(negedge clk); #1;
    n_total++; if (dbg_state !== BOOT || imem_req !== 1'b0) $display("FAIL zw_boot: got st=%0d req=%b want st=0 req=0", dbg_state, imem_req); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (dbg_state !== FETCH || imem_req !== 1'b0) $display("FAIL zw_fetch: got st=%0d req=%b want st=1 req=0", dbg_state, imem_req); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL zw_req0: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0) $display("FAIL zw_first_fv: got fv=%b pc=%h want fv=1 pc=0", fetch_valid, fetch_pc); else n_pass++;
    n_total++; if (stall_cycles !== 32'd2) $display("FAIL zw_stall: got %0d want 2", stall_cycles); else n_pass++;
    exp_q = '{32'h0, 32'h4, 32'h8};
    wait_deliv(3, ok);
    n_total++;
    if (!ok) $display("FAIL zw_deliv_timeout: got %0d entries want 3", got_q.size());
    else begin
      n_pass++;
      for (int k = 0; k < 3; k++) begin
        n_total++; if (got_q[k][63:32] !== exp_q[k]) $display("FAIL zw_pc%0d: got %h want %h", k, got_q[k][63:32], exp_q[k]); else n_pass++;
        n_total++; if (got_q[k][31:0] !== mem_word(exp_q[k])) $display("FAIL zw_instr%0d: got %h want %h", k, got_q[k][31:0], mem_word(exp_q[k])); else n_pass++;
        n_total++; if (ack_q[k] !== exp_q[k]) $display("FAIL zw_addr%0d: got %h want %h", k, ack_q[k], exp_q[k]); else n_pass++;
      end
    end
  endtask

  task automatic test_latency();
    bit ok;
    int held;
    mem_wait = 2; id_ready = 1'b1;
    do_reset();
    wait_req(ok);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req && imem_addr == 32'h0) held++;
      if (imem_ack) break;
      @(negedge clk); #1;
    end
    n_total++; if (held !== 3) $display("FAIL lat_hold: got %0d cycles want 3", held); else n_pass++;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    wait_deliv(4, ok);
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if (!ok || got_q.size() != 4) $display("FAIL lat_count: got %0d deliveries want 4", got_q.size());
    else begin
      n_pass++;
      for (int k = 0; k < 4; k++) begin
        n_total++; if (got_q[k][63:32] !== exp_q[k]) $display("FAIL lat_pc%0d: got %h want %h", k, got_q[k][63:32], exp_q[k]); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int req_seen;
    mem_wait = 0; id_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    #1;
    n_total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0) $display("FAIL bp_head: got fv=%b pc=%h want fv=1 pc=0", fetch_valid, fetch_pc); else n_pass++;
    n_total++; if (fetch_instr !== mem_word(32'h0)) $display("FAIL bp_instr: got %h want %h", fetch_instr, mem_word(32'h0)); else n_pass++;
    n_total++; if (ack_q.size() != 2) $display("FAIL bp_fill: got %0d requests want 2", ack_q.size()); else n_pass++;
    n_total++; if (stall_cycles !== 32'd2) $display("FAIL bp_stall: got %0d want 2", stall_cycles); else n_pass++;
    req_seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (imem_req) req_seen++;
      @(negedge clk); #1;
    end
    n_total++; if (req_seen !== 0) $display("FAIL bp_req_idle: got %0d req cycles want 0", req_seen); else n_pass++;
    @(posedge clk); #1;
    id_ready = 1'b1;
    exp_q = '{32'h0, 32'h4, 32'h8};
    wait_deliv(3, ok);
    n_total++;
    if (!ok) $display("FAIL bp_deliv_timeout: got %0d entries want 3", got_q.size());
    else begin
      n_pass++;
      for (int k = 0; k < 3; k++) begin
        n_total++; if (got_q[k][63:32] !== exp_q[k]) $display("FAIL bp_pc%0d: got %h want %h", k, got_q[k][63:32], exp_q[k]); else n_pass++;
      end
    end
  endtask

  task automatic test_redirect_drain();
    bit ok;
    mem_wait = 2; id_ready = 1'b1;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (imem_req && imem_addr == 32'h8) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    n_total++; if (!ok) $display("FAIL dr_req8_timeout: got none want req 0x8"); else n_pass++;
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_target = 32'h0000_0100;
    got_q.delete(); ack_q.delete();
    @(negedge clk); #1;
    n_total++; if (fetch_valid !== 1'b0) $display("FAIL dr_fv_forced: got %b want 0", fetch_valid); else n_pass++;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk); #1;
    n_total++; if (dbg_state !== DRAIN) $display("FAIL dr_state: got %0d want %0d", dbg_state, DRAIN); else n_pass++;
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) $display("FAIL dr_hold: got req=%b addr=%h want req=1 addr=8", imem_req, imem_addr); else n_pass++;
    wait_deliv(1, ok);
    n_total++;
    if (!ok) $display("FAIL dr_deliv_timeout: got %0d entries want 1", got_q.size());
    else begin
      n_pass++;
      n_total++; if (got_q[0][63:32] !== 32'h100) $display("FAIL dr_first_pc: got %h want 100", got_q[0][63:32]); else n_pass++;
      n_total++; if (ack_q.size() != 2 || ack_q[1] !== 32'h100) $display("FAIL dr_next_req: got n=%0d want 2 with 2nd addr 100", ack_q.size()); else n_pass++;
    end
  endtask

  task automatic test_redirect_ack();
    bit ok;
    mem_wait = 1; id_ready = 1'b0;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (imem_req && imem_addr == 32'h4 && !imem_ack) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    n_total++; if (!ok) $display("FAIL ra_req4_timeout: got none want req 0x4"); else n_pass++;
    n_total++; if (fetch_valid !== 1'b1) $display("FAIL ra_buf_loaded: got %b want 1", fetch_valid); else n_pass++;
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_target = 32'h0000_0203;
    @(negedge clk); #1;
    n_total++; if (fetch_valid !== 1'b0 || dbg_state !== WAIT) $display("FAIL ra_coincide: got fv=%b st=%0d want fv=0 st=%0d", fetch_valid, dbg_state, WAIT); else n_pass++;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk); #1;
    n_total++; if (dbg_state !== FETCH) $display("FAIL ra_state: got %0d want %0d", dbg_state, FETCH); else n_pass++;
    n_total++; if (fetch_valid !== 1'b0 || fetch_pc !== 32'h0) $display("FAIL ra_flushed: got fv=%b pc=%h want fv=0 pc=0", fetch_valid, fetch_pc); else n_pass++;
    wait_req(ok);
    n_total++; if (!ok || imem_addr !== 32'h200) $display("FAIL ra_next_addr: got %h want 200", imem_addr); else n_pass++;
    id_ready = 1'b1;
    wait_deliv(1, ok);
    n_total++;
    if (!ok) $display("FAIL ra_deliv_timeout: got %0d entries want 1", got_q.size());
    else begin
      n_pass++;
      n_total++; if (got_q[0] !== {32'h200, mem_word(32'h200)}) $display("FAIL ra_first: got %h want %h", got_q[0], {32'h200, mem_word(32'h200)}); else n_pass++;
    end
  endtask

  task automatic test_wrap_reset();
    bit ok;
    mem_wait = 0; id_ready = 1'b1;
    do_reset();
    repeat (6) @(posedge clk);
    #1;
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFE;
    got_q.delete();
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    got_q.delete(); ack_q.delete();
    exp_q = '{32'hFFFF_FFFC, 32'h0};
    wait_deliv(2, ok);
    n_total++;
    if (!ok) $display("FAIL wr_deliv_timeout: got %0d entries want 2", got_q.size());
    else begin
      n_pass++;
      for (int k = 0; k < 2; k++) begin
        n_total++; if (got_q[k][63:32] !== exp_q[k]) $display("FAIL wr_pc%0d: got %h want %h", k, got_q[k][63:32], exp_q[k]); else n_pass++;
        n_total++; if (ack_q[k] !== exp_q[k]) $display("FAIL wr_addr%0d: got %h want %h", k, ack_q[k], exp_q[k]); else n_pass++;
      end
    end
    mem_wait = 3;
    wait_req(ok);
    n_total++; if (!ok || dbg_state !== WAIT) $display("FAIL wr_midwait: got st=%0d want %0d", dbg_state, WAIT); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) $display("FAIL wr_rst_req: got req=%b addr=%h want req=0 addr=0", imem_req, imem_addr); else n_pass++;
    n_total++; if (dbg_state !== BOOT || stall_cycles !== 32'h0) $display("FAIL wr_rst_state: got st=%0d stall=%0d want st=0 stall=0", dbg_state, stall_cycles); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_wait = 0;
    got_q.delete(); ack_q.delete();
    wait_req(ok);
    n_total++; if (!ok || imem_addr !== 32'h0) $display("FAIL wr_reset_pc: got %h want 0", imem_addr); else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_backpressure();
    test_redirect_drain();
    test_redirect_ack();
    test_wrap_reset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer between the PC/redirect logic and a variable-latency instruction memory (req/ack handshake, one outstanding request). It owns the fetch PC, issues sequential fetches, and buffers returned instructions in a small FIFO toward ID. It handles EX redirects (taken branch/JAL/JALR) and ID back-pressure. It replaces the free-running PC register when IMEM is not single-cycle.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
BUF_DEPTH, 2, fetch buffer entries (power of 2, >=2)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
redirect_valid  input  1  EX redirect (pc_select), single-cycle pulse
redirect_target  input  32  redirect address (alu_result_EX); bits [1:0] forced to 0
id_ready  input  1  ID accepts head instruction this cycle
imem_req  output  1  instruction request
imem_addr  output  32  request address
imem_ack  input  1  data valid pulse for the outstanding request
imem_rdata  input  32  instruction word, valid with imem_ack
fetch_valid  output  1  head entry valid toward ID
fetch_pc  output  32  PC of head entry
fetch_instr  output  32  instruction of head entry
stall_cycles  output  32  saturating count of cycles with fetch_valid=0 after reset

Behaviour:
- Reset (async): state=BOOT, next_pc=RESET_PC, buffer empty, imem_req=0, imem_addr=0, fetch_valid=0, fetch_pc=0, fetch_instr=0, stall_cycles=0.
- States: BOOT, FETCH, WAIT, DRAIN.
- BOOT: one cycle with imem_req=0, then FETCH.
- FETCH: if (count < BUF_DEPTH) and no redirect: assert imem_req with imem_addr=next_pc, go to WAIT. Otherwise deassert imem_req and stay in FETCH.
- WAIT: imem_req stays 1 and imem_addr stays stable until imem_ack. imem_ack in the same cycle as the request is legal (0-wait memory).
  - On ack with no redirect: push {imem_addr, imem_rdata}, next_pc <= imem_addr+4 (mod 2^32, wraps at 32'hFFFF_FFFC->0), return to FETCH.
  - Throughput: one instruction per 2 cycles minimum. The request may re-issue in the cycle after ack.
- Redirect (any state): buffer flushed at the next edge. next_pc <= {redirect_target[31:2],2'b00}. fetch_valid is forced to 0 in the redirect cycle, so no pop occurs.
  - If a request is outstanding and imem_ack=0 that cycle: go to DRAIN.
  - If imem_ack=1 in the same cycle: the data is discarded and the state goes to FETCH.
- DRAIN: imem_req/imem_addr are held at the old request until ack. The ack data is discarded, then go to FETCH. A further redirect in DRAIN overwrites next_pc and the state stays in DRAIN.
- Buffer: FIFO of {pc,instr}. Pop when fetch_valid && id_ready. Push and pop in the same cycle are allowed when full or empty. Empty-buffer bypass is not permitted (ack data appears on fetch_valid the cycle after ack).
- fetch_valid = !empty && !redirect_valid. fetch_pc/fetch_instr show the head entry and are 0 when empty.
- stall_cycles increments when fetch_valid=0 and state!=BOOT. It saturates at 32'hFFFF_FFFF.
- The request gate is evaluated on current count, so a pop in the same cycle does not enable an issue. This keeps the timing path short.
- imem_ack outside WAIT/DRAIN is ignored (assertion fires in simulation).

Decomposition:
- riscv_pkg gains the typedef enum fetch_state_e {BOOT, FETCH, WAIT, DRAIN} and the constant INSTR_BYTES=4.
- Sub-module fetch_buffer (parameterised FIFO, flush input, count output). The FSM, PC register and counter stay in fetch_ctrl.

Test Plan:
- Reset, 0-wait memory (ack same cycle as req), id_ready=1 -> imem_addr sequence 0x0,0x4,0x8; fetch_pc 0x0 appears 2 cycles after reset release plus BOOT.
- 3-cycle ack latency, id_ready=1 -> imem_addr held stable 3 cycles; each fetch_pc delivered exactly once, no duplicates.
- id_ready=0 for 10 cycles, 0-wait memory -> buffer fills to 2 (0x0,0x4), imem_req=0 afterwards; on id_ready=1, 0x0 then 0x4 then 0x8 issued.
- Redirect to 0x100 while request for 0x8 is outstanding (ack 2 cycles later) -> DRAIN; 0x8 data is discarded; next request is 0x100; first fetch_valid shows fetch_pc=0x100.
- Redirect coincident with ack, target 0x203 -> ack data dropped, buffer flushed, next imem_addr=0x200.
- next_pc=0xFFFF_FFFC after a redirect, plus assert reset mid-WAIT -> the address after 0xFFFF_FFFC wraps to 0x0. Reset mid-WAIT clears imem_req immediately; the first request after reset goes to RESET_PC.
